// File: rtl/uart_prog_loader.sv
// UART program loader: receives 8N1 bytes, packs them little-endian into 32-bit
// words and issues one write strobe per word until the last address is written.
module uart_prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned TIMEOUT_CLKS = 1_000_000,
  parameter logic [14:0] LAST_ADR     = 15'h7FFF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic        rx,
  output logic        upg_wen,
  output logic [14:0] upg_adr,
  output logic [31:0] upg_dat,
  output logic        upg_done,
  output logic        frame_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [CNT_W-1:0]  HALF_M1    = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_M1    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDLE_W-1:0] TIMEOUT_M1 = IDLE_W'(TIMEOUT_CLKS - 1);

  logic              rx_meta_q, rx_sync_q;
  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       word_q, word_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [14:0]       adr_cnt_q, adr_cnt_d;
  logic              wen_q, wen_d;
  logic [14:0]       adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;

  // Synchronizer idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    idle_cnt_d = idle_cnt_q;
    adr_cnt_d  = adr_cnt_q;
    wen_d      = 1'b0;
    adr_d      = adr_q;
    dat_d      = dat_q;
    done_d     = done_q;
    ferr_d     = ferr_q;

    if (wen_q) begin
      if (adr_cnt_q == LAST_ADR) done_d = 1'b1;
      else                       adr_cnt_d = adr_cnt_q + 15'd1;
    end

    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        if (!rx_sync_q && !done_q) begin
          state_d = ST_START;
        end else if (byte_cnt_q != 2'd0) begin
          if (idle_cnt_q == TIMEOUT_M1) begin
            byte_cnt_d = 2'd0;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end
      ST_START: begin
        if (clk_cnt_q == HALF_M1) begin
          clk_cnt_d = '0;
          bit_cnt_d = 3'd0;
          state_d   = rx_sync_q ? ST_IDLE : ST_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          state_d   = ST_IDLE;
          if (rx_sync_q) begin
            idle_cnt_d = '0;
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
              2'd0:    word_d[7:0]   = shift_q;
              2'd1:    word_d[15:8]  = shift_q;
              2'd2:    word_d[23:16] = shift_q;
              default: begin
                wen_d = 1'b1;
                adr_d = adr_cnt_q;
                dat_d = {shift_q, word_q};
              end
            endcase
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
    endcase

    // Disabling the loader wipes progress but leaves the last write visible.
    if (!en) begin
      state_d    = ST_IDLE;
      clk_cnt_d  = '0;
      byte_cnt_d = 2'd0;
      idle_cnt_d = '0;
      adr_cnt_d  = 15'd0;
      wen_d      = 1'b0;
      done_d     = 1'b0;
      ferr_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      byte_cnt_q <= 2'd0;
      word_q     <= 24'd0;
      idle_cnt_q <= '0;
      adr_cnt_q  <= 15'd0;
      wen_q      <= 1'b0;
      adr_q      <= 15'd0;
      dat_q      <= 32'd0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      idle_cnt_q <= idle_cnt_d;
      adr_cnt_q  <= adr_cnt_d;
      wen_q      <= wen_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
    end
  end

  // Gating with en keeps the strobe low in the cycle en drops.
  assign upg_wen   = wen_q & en;
  assign upg_adr   = adr_q;
  assign upg_dat   = dat_q;
  assign upg_done  = done_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: a byte-level reference model queues
// expected writes, a monitor pops and compares them on every write strobe.
module tb_uart_prog_loader;

  localparam int          CPB  = 16;
  localparam int          TMO  = 2000;
  localparam logic [14:0] LAST = 15'h0003;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic        rx = 1'b1;
  logic        upg_wen;
  logic [14:0] upg_adr;
  logic [31:0] upg_dat;
  logic        upg_done;
  logic        frame_err;

  uart_prog_loader #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_CLKS(TMO),
    .LAST_ADR    (LAST)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .rx       (rx),
    .upg_wen  (upg_wen),
    .upg_adr  (upg_adr),
    .upg_dat  (upg_dat),
    .upg_done (upg_done),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [14:0] adr;
    logic [31:0] dat;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: bytes in flight, word address, done and error flags.
  logic [7:0] m_part[$];
  int         m_adr;
  bit         m_done;
  bit         m_ferr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void m_clear();
    m_part.delete();
    m_adr  = 0;
    m_done = 1'b0;
    m_ferr = 1'b0;
  endfunction

  function automatic void m_frame(input logic [7:0] b, input bit ok);
    wr_t w;
    if (m_done) return;
    if (!ok) begin
      m_ferr = 1'b1;
      return;
    end
    m_part.push_back(b);
    if (m_part.size() == 4) begin
      w.adr = 15'(m_adr);
      w.dat = {m_part[3], m_part[2], m_part[1], m_part[0]};
      exp_q.push_back(w);
      m_part.delete();
      if (15'(m_adr) == LAST) m_done = 1'b1;
      else                    m_adr++;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    if (n > TMO) m_part.delete();
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input bit ok);
    m_frame(b, ok);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
    rx = ok;
    repeat (CPB) tick();
    rx = 1'b1;
    repeat (2 * CPB) tick();
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_frame(w[8*k +: 8], 1'b1);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
    check(name, exp_q.size(), 0);
  endtask

  task automatic en_pulse();
    tick();
    en = 1'b0;
    m_clear();
    tick();
    en = 1'b1;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wen"},  upg_wen,   1'b0);
    check({tag, "_adr"},  upg_adr,   15'd0);
    check({tag, "_dat"},  upg_dat,   32'd0);
    check({tag, "_done"}, upg_done,  1'b0);
    check({tag, "_ferr"}, frame_err, 1'b0);
  endtask

  // Monitor: every strobe must match the oldest expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (upg_wen) begin
        check("wen_only_when_enabled", en, 1'b1);
        if (exp_q.size() == 0) begin
          check("unexpected_write", upg_wen, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          check("write_adr", upg_adr, mon_e.adr);
          check("write_dat", upg_dat, mon_e.dat);
        end
      end
    end
  end

  initial begin
    m_clear();
    repeat (3) tick();
    check_all_zero("reset");
    rstn = 1'b1;
    tick();
    en = 1'b1;
    tick();

    // Single word, then outputs hold after the strobe.
    send_word(32'h12345678);
    wait_drain("drain_single");
    repeat (5) tick();
    check("hold_adr", upg_adr, 15'd0);
    check("hold_dat", upg_dat, 32'h12345678);

    // Four words reach the last address; a further byte is ignored.
    en_pulse();
    for (int w = 0; w < 4; w++) send_word($urandom());
    wait_drain("drain_four");
    check("done_after_last", upg_done, m_done);
    send_frame(8'($urandom()), 1'b1);
    wait_drain("drain_after_done");
    check("done_stays", upg_done, 1'b1);
    check("adr_no_wrap", upg_adr, LAST);
    en_pulse();
    check("done_cleared_by_en", upg_done, 1'b0);

    // Bad stop bit drops the byte and sets the sticky error.
    send_frame(8'hAA, 1'b0);
    send_word(32'h44332211);
    wait_drain("drain_ferr");
    check("frame_err_set", frame_err, m_ferr);
    en_pulse();
    check("frame_err_cleared", frame_err, 1'b0);

    // Partial word discarded after the idle timeout.
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    idle(2500);
    send_word(32'h44332211);
    wait_drain("drain_timeout");

    // Short low glitch produces nothing.
    en_pulse();
    rx = 1'b0;
    repeat (5) tick();
    rx = 1'b1;
    idle(100);
    check("glitch_no_ferr", frame_err, 1'b0);
    send_word($urandom());
    wait_drain("drain_after_glitch");

    // en low for one clock restarts addressing at 0.
    en_pulse();
    send_word($urandom());
    send_word($urandom());
    wait_drain("drain_two_words");
    en_pulse();
    send_word(32'hDEADBEEF);
    wait_drain("drain_deadbeef");

    // Random traffic with occasional bad stop bits and long pauses.
    en_pulse();
    repeat (24) begin
      if ($urandom_range(0, 9) == 0) idle(2500);
      send_frame(8'($urandom()), $urandom_range(0, 7) != 0);
    end
    wait_drain("drain_random");
    check("random_ferr", frame_err, m_ferr);
    check("random_done", upg_done, m_done);

    // Asynchronous reset in the middle of a byte.
    en_pulse();
    send_word($urandom() | 32'h1);
    wait_drain("drain_before_reset");
    rx = 1'b0;
    repeat (40) tick();
    #1 rstn = 1'b0;
    #1 check_all_zero("async_reset");
    m_clear();
    rx = 1'b1;
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    send_word(32'hCAFEF00D);
    wait_drain("drain_after_reset");

    repeat (10) tick();
    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
